// File: rtl/wb_pkg.sv
// Shared types and cell-code constants for the writeback packet arbiter.
package wb_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} wb_arb_state_t;

    localparam int unsigned CELL_W      = 3;
    localparam int unsigned CELL_CODE_W = 3 * CELL_W;

    localparam logic [CELL_W-1:0] CELL_1 = 3'b001;
    localparam logic [CELL_W-1:0] CELL_2 = 3'b010;
    localparam logic [CELL_W-1:0] CELL_3 = 3'b011;

    // Codes are {z, y, x}; CELL_2 is the home offset on an axis.
    localparam int NUM_HALF_SHELL = 13;
    localparam logic [CELL_CODE_W-1:0] HALF_SHELL_CODES [NUM_HALF_SHELL] = '{
        {CELL_3, CELL_1, CELL_1}, {CELL_3, CELL_1, CELL_2}, {CELL_3, CELL_1, CELL_3},
        {CELL_3, CELL_2, CELL_1}, {CELL_3, CELL_2, CELL_2}, {CELL_3, CELL_2, CELL_3},
        {CELL_3, CELL_3, CELL_1}, {CELL_3, CELL_3, CELL_2}, {CELL_3, CELL_3, CELL_3},
        {CELL_2, CELL_3, CELL_1}, {CELL_2, CELL_3, CELL_2}, {CELL_2, CELL_3, CELL_3},
        {CELL_2, CELL_2, CELL_3}
    };

    localparam logic [CELL_CODE_W-1:0] CELL_LEGAL_DEFAULT = {CELL_2, CELL_2, CELL_3};

    function automatic logic is_half_shell(input logic [CELL_CODE_W-1:0] code);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_HALF_SHELL; i++) begin
            if (HALF_SHELL_CODES[i] == code) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/cell_to_dest_id_map.sv
// Maps a relative {z,y,x} cell code (CELL_2 = home) to a destination node ID on a
// periodic NX*NY*NZ grid, numbered so that the home cell is HOME_CELL_ID.
module cell_to_dest_id_map #(
    parameter int unsigned CELL_ID_WIDTH = 3,
    parameter int unsigned NODE_ID_WIDTH = 6,
    parameter int unsigned NUM_CELLS     = 64,
    parameter int unsigned HOME_CELL_ID  = 0,
    parameter int unsigned HOME_X        = 1,
    parameter int unsigned HOME_Y        = 1,
    parameter int unsigned HOME_Z        = 1,
    parameter int unsigned NX            = 4,
    parameter int unsigned NY            = 4,
    parameter int unsigned NZ            = 4
) (
    input  logic [CELL_ID_WIDTH-1:0] cell_x,
    input  logic [CELL_ID_WIDTH-1:0] cell_y,
    input  logic [CELL_ID_WIDTH-1:0] cell_z,
    output logic [NODE_ID_WIDTH-1:0] dest_id
);

    localparam int HOME_LIN = (int'(HOME_X) - 1)
        + int'(NX) * ((int'(HOME_Y) - 1) + int'(NY) * (int'(HOME_Z) - 1));

    int dx, dy, dz, lin, id;

    // Grid coordinates are 1-based; wrap the offset home position into 0..N-1.
    always_comb begin
        dx  = (int'(HOME_X) - 1 + int'(cell_x) - 2 + 2 * int'(NX)) % int'(NX);
        dy  = (int'(HOME_Y) - 1 + int'(cell_y) - 2 + 2 * int'(NY)) % int'(NY);
        dz  = (int'(HOME_Z) - 1 + int'(cell_z) - 2 + 2 * int'(NZ)) % int'(NZ);
        lin = dx + int'(NX) * (dy + int'(NY) * dz);
        id  = (lin - HOME_LIN + int'(HOME_CELL_ID) + int'(NUM_CELLS)) % int'(NUM_CELLS);
        dest_id = NODE_ID_WIDTH'(id);
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from ptr, wrapping, and grants the first request.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 13,
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    localparam int unsigned SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] cand;
    logic             found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + SUM_W'(k);
            if (cand >= SUM_W'(NUM_REQ)) cand = cand - SUM_W'(NUM_REQ);
            if (en && !found && req[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = cand[IDX_W-1:0];
            end
        end
        if (found) grant[idx] = 1'b1;
    end

endmodule

// File: rtl/wb_pkt_arbiter.sv
// Force writeback scheduler: round-robin over half-shell sources into one mapped packet port.
// Define WB_ARB_CELL_CHECK_EN to drop non-half-shell records and flag them on err_cell.
module wb_pkt_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned NUM_REQ           = 13,
    parameter int unsigned DATA_WIDTH        = 32,
    parameter int unsigned CELL_ID_WIDTH     = 3,
    parameter int unsigned PARTICLE_ID_WIDTH = 7,
    parameter int unsigned ID_WIDTH          = 3 * CELL_ID_WIDTH + PARTICLE_ID_WIDTH,
    parameter int unsigned WB_WIDTH          = ID_WIDTH + 3 * DATA_WIDTH,
    parameter int unsigned NODE_ID_WIDTH     = 6,
    parameter int unsigned PACKET_WIDTH      = 3 * DATA_WIDTH + PARTICLE_ID_WIDTH + NODE_ID_WIDTH,
    parameter int unsigned NUM_CELLS         = 64,
    parameter int unsigned HOME_CELL_ID      = 0,
    parameter int unsigned HOME_X            = 1,
    parameter int unsigned HOME_Y            = 1,
    parameter int unsigned HOME_Z            = 1,
    parameter int unsigned NX                = 4,
    parameter int unsigned NY                = 4,
    parameter int unsigned NZ                = 4,
    parameter int unsigned CNT_WIDTH         = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          phase_start,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*WB_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]            req_done,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          pkt_valid,
    output logic [PACKET_WIDTH-1:0]       pkt_data,
    input  logic                          pkt_ready,
    output logic                          busy,
    output logic                          phase_done,
    output logic [CNT_WIDTH-1:0]          pkt_count
`ifdef WB_ARB_CELL_CHECK_EN
    ,
    output logic                          err_cell
`endif
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CODE_W = 3 * CELL_ID_WIDTH;

    wb_arb_state_t state_q, state_d;
    logic [NUM_REQ-1:0]      done_mask_q, done_mask_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0]    count_q, count_d;
    logic                    pkt_valid_q;
    logic [PACKET_WIDTH-1:0] pkt_data_q;

    logic [WB_WIDTH-1:0]     rec [NUM_REQ];
    logic [WB_WIDTH-1:0]     win_rec;
    logic [NUM_REQ-1:0]      grant;
    logic [IDX_W-1:0]        win_idx;
    logic                    arb_en, can_accept, xfer_in, load, start;
    logic [CODE_W-1:0]       cell_code, map_code;
    logic [NODE_ID_WIDTH-1:0] dest_id;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign rec[g] = req_data[g*WB_WIDTH +: WB_WIDTH];
    end

    assign can_accept = !pkt_valid_q || pkt_ready;
    assign start      = (state_q == IDLE) && phase_start;
    assign win_rec    = rec[win_idx];
    assign cell_code  = win_rec[WB_WIDTH-1 -: CODE_W];
    assign xfer_in    = |grant;
    assign req_ready  = grant;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req   (req_valid),
        .en    (arb_en),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (win_idx)
    );

`ifdef WB_ARB_CELL_CHECK_EN
    logic cell_ok;
    logic err_cell_q;

    assign cell_ok  = is_half_shell(cell_code);
    assign map_code = cell_ok ? cell_code : CELL_LEGAL_DEFAULT;
    assign load     = xfer_in && cell_ok;
    assign err_cell = err_cell_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cell_q <= 1'b0;
        end else if (start) begin
            err_cell_q <= 1'b0;
        end else if (xfer_in && !cell_ok) begin
            err_cell_q <= 1'b1;
        end
    end
`else
    assign map_code = cell_code;
    assign load     = xfer_in;
`endif

    cell_to_dest_id_map #(
        .CELL_ID_WIDTH (CELL_ID_WIDTH),
        .NODE_ID_WIDTH (NODE_ID_WIDTH),
        .NUM_CELLS     (NUM_CELLS),
        .HOME_CELL_ID  (HOME_CELL_ID),
        .HOME_X        (HOME_X),
        .HOME_Y        (HOME_Y),
        .HOME_Z        (HOME_Z),
        .NX            (NX),
        .NY            (NY),
        .NZ            (NZ)
    ) u_map (
        .cell_x  (map_code[CELL_ID_WIDTH-1:0]),
        .cell_y  (map_code[2*CELL_ID_WIDTH-1:CELL_ID_WIDTH]),
        .cell_z  (map_code[3*CELL_ID_WIDTH-1:2*CELL_ID_WIDTH]),
        .dest_id (dest_id)
    );

    always_comb begin
        state_d     = state_q;
        done_mask_d = done_mask_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        arb_en      = 1'b0;
        phase_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (phase_start) begin
                    state_d     = RUN;
                    done_mask_d = '0;
                end
            end
            RUN: begin
                arb_en      = can_accept;
                done_mask_d = done_mask_q | req_done;
                if ((&done_mask_q) && (req_valid == '0)) state_d = DRAIN;
            end
            DRAIN: begin
                if (can_accept) state_d = DONE;
            end
            DONE: begin
                phase_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            ptr_d = '0;
        end else if (xfer_in) begin
            ptr_d = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end

        if (start) begin
            count_d = '0;
        end else if (pkt_valid_q && pkt_ready && !(&count_q)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            done_mask_q <= '0;
            ptr_q       <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            done_mask_q <= done_mask_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_valid_q <= 1'b0;
            pkt_data_q  <= '0;
        end else if (load) begin
            pkt_valid_q <= 1'b1;
            pkt_data_q  <= {dest_id, win_rec[3*DATA_WIDTH +: PARTICLE_ID_WIDTH],
                            win_rec[3*DATA_WIDTH-1:0]};
        end else if (pkt_ready) begin
            pkt_valid_q <= 1'b0;
        end
    end

    assign pkt_valid = pkt_valid_q;
    assign pkt_data  = pkt_data_q;
    assign pkt_count = count_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_wb_pkt_arbiter.sv
// Scoreboard bench for wb_pkt_arbiter; define WB_ARB_CELL_CHECK_EN to also cover err_cell.
module tb_wb_pkt_arbiter;

    localparam int NR   = 13;
    localparam int WBW  = 112;
    localparam int PKW  = 109;
    localparam int CNTW = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              phase_start;
    logic [NR-1:0]     req_valid, req_done, req_ready;
    logic [NR*WBW-1:0] req_data;
    logic              pkt_valid, pkt_ready, busy, phase_done;
    logic [PKW-1:0]    pkt_data;
    logic [CNTW-1:0]   pkt_count;
`ifdef WB_ARB_CELL_CHECK_EN
    logic              err_cell;
`endif

    wb_pkt_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .phase_start (phase_start),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_done    (req_done),
        .req_ready   (req_ready),
        .pkt_valid   (pkt_valid),
        .pkt_data    (pkt_data),
        .pkt_ready   (pkt_ready),
        .busy        (busy),
        .phase_done  (phase_done),
        .pkt_count   (pkt_count)
`ifdef WB_ARB_CELL_CHECK_EN
        ,
        .err_cell    (err_cell)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [WBW-1:0] rq [NR][$];
    logic [PKW-1:0] exp_q [$];
    int             win_log [$];
    int             rr_next, phase_exp, last_xfer_cyc, pd_cyc;
    bit             exp_err, auto_done, pd_seen;
    int             gap_pct, ready_pct;
    logic [PKW-1:0] last_pkt;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", nm, act, req);
        end
    endtask

    // Half shell: everything above home in z, then above in y, then +x.
    function automatic bit is_legal(input logic [8:0] code);
        int z, y, x;
        z = int'(code[8:6]);
        y = int'(code[5:3]);
        x = int'(code[2:0]);
        return (z == 3 && y >= 1 && y <= 3 && x >= 1 && x <= 3) ||
               (z == 2 && y == 3 && x >= 1 && x <= 3) || (z == 2 && y == 2 && x == 3);
    endfunction

    // Home (1,1,1) on a periodic 4x4x4 grid, home numbered 0.
    function automatic int axis_pos(input int code);
        int p;
        p = 1 + (code - 2);
        if (p < 1) p += 4;
        if (p > 4) p -= 4;
        return p;
    endfunction

    function automatic logic [PKW-1:0] exp_pkt(input logic [WBW-1:0] r);
        int nx, ny, nz, id;
        logic [8:0] code;
        code = r[WBW-1 -: 9];
        nx = axis_pos(int'(code[2:0]));
        ny = axis_pos(int'(code[5:3]));
        nz = axis_pos(int'(code[8:6]));
        id = (nx - 1) + 4 * (ny - 1) + 16 * (nz - 1);
        return {6'(id), r[102:0]};
    endfunction

    function automatic logic [WBW-1:0] mk_rec(input logic [8:0] code);
        return {code, 7'($urandom), $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [WBW-1:0] rand_rec();
        logic [8:0] code;
        code = '0;
        while (!is_legal(code)) code = {3'($urandom_range(3, 1)), 3'($urandom_range(3, 1)),
                                        3'($urandom_range(3, 1))};
        return mk_rec(code);
    endfunction

    task automatic step();
        logic [NR-1:0]  eg;
        logic [WBW-1:0] r;
        bit             found;
        int             i;
        @(negedge clk);
        if (rst_n) begin
            eg = '0;
            found = 1'b0;
            if (busy && (!pkt_valid || pkt_ready)) begin
                for (int k = 0; k < NR; k++) begin
                    i = (rr_next + k) % NR;
                    if (!found && req_valid[i]) begin
                        eg[i] = 1'b1;
                        found = 1'b1;
                    end
                end
            end
            chk("req_ready", 128'(req_ready), 128'(eg));
            for (int j = 0; j < NR; j++) begin
                if (req_valid[j] && req_ready[j] && rq[j].size() > 0) begin
                    r = rq[j].pop_front();
                    if (is_legal(r[WBW-1 -: 9])) begin
                        exp_q.push_back(exp_pkt(r));
                        phase_exp++;
                    end else begin
                        exp_err = 1'b1;
                    end
                    rr_next = (j + 1) % NR;
                    win_log.push_back(j);
                end
            end
            pd_seen = phase_done;
            if (phase_done) begin
                pd_cyc = cyc;
                chk("pkt_count", 128'(pkt_count), 128'(phase_exp));
                chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
`ifdef WB_ARB_CELL_CHECK_EN
                chk("err_cell", 128'(err_cell), 128'(exp_err));
`endif
            end
        end
        @(posedge clk);
        #1;
        phase_start = 1'b0;
        for (int j = 0; j < NR; j++) begin
            bit d, gap;
            d = auto_done && rq[j].size() <= 1;
            gap = ($urandom_range(99) < gap_pct);
            req_done[j] = d;
            req_valid[j] = (rq[j].size() > 0) && (!gap || d);
            req_data[j*WBW +: WBW] = (rq[j].size() > 0) ? rq[j][0] : '0;
        end
        pkt_ready = ($urandom_range(99) < ready_pct);
    endtask

    task automatic start_phase();
        phase_start = 1'b1;
        rr_next = 0;
        phase_exp = 0;
        exp_err = 1'b0;
        win_log.delete();
        step();
    endtask

    task automatic run_phase(input int budget);
        int n;
        n = 0;
        pd_seen = 1'b0;
        while (!pd_seen && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (!pd_seen) begin
            errors++;
            $display("FAIL phase_done_timeout actual none required pulse within %0d", budget);
        end
        chk("phase_done_pulse", 128'(phase_done), 128'(0));
        chk("idle_busy", 128'(busy), 128'(0));
    endtask

    // Output-side monitor: pops the scoreboard on every packet transfer.
    initial begin
        bit             hold_v;
        logic [PKW-1:0] hold_d;
        hold_v = 1'b0;
        hold_d = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    chk("hold_valid", 128'(pkt_valid), 128'(1));
                    chk("hold_data", 128'(pkt_data), 128'(hold_d));
                end
                if (pkt_valid && pkt_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pkt actual %0h required none", pkt_data);
                    end else begin
                        chk("pkt_data", 128'(pkt_data), 128'(exp_q.pop_front()));
                    end
                    last_pkt = pkt_data;
                    last_xfer_cyc = cyc;
                end
                hold_v = pkt_valid && !pkt_ready;
                hold_d = pkt_data;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        int n;
        rst_n = 1'b0;
        phase_start = 1'b0;
        req_valid = '0;
        req_done = '0;
        req_data = '0;
        pkt_ready = 1'b1;
        auto_done = 1'b0;
        gap_pct = 0;
        ready_pct = 100;
        rr_next = 0;
        phase_exp = 0;
        exp_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pkt_valid", 128'(pkt_valid), 128'(0));
        chk("rst_pkt_data", 128'(pkt_data), 128'(0));
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_phase_done", 128'(phase_done), 128'(0));
        chk("rst_pkt_count", 128'(pkt_count), 128'(0));
        rst_n = 1'b1;
        step();

        // Single record to cell {2,2,3}, i.e. node 1.
        rq[0].push_back(mk_rec({3'd2, 3'd2, 3'd3}));
        auto_done = 1'b1;
        start_phase();
        run_phase(50);
        chk("dest_id", 128'(last_pkt[PKW-1 -: 6]), 128'(1));
        chk("done_latency", 128'(pd_cyc - last_xfer_cyc), 128'(2));

        // All requesters busy: strict rotation.
        auto_done = 1'b0;
        for (int i = 0; i < NR; i++) repeat (3) rq[i].push_back(rand_rec());
        start_phase();
        repeat (14) step();
        chk("rot_count", 128'(win_log.size()), 128'(14));
        for (int k = 0; k < 14 && k < win_log.size(); k++)
            chk("rot_order", 128'(win_log[k]), 128'(k % NR));
        auto_done = 1'b1;
        run_phase(200);

        // Backpressure for five cycles.
        auto_done = 1'b0;
        foreach (rq[i]) if (i == 2 || i == 5 || i == 9) repeat (3) rq[i].push_back(rand_rec());
        start_phase();
        repeat (2) step();
        ready_pct = 0;
        repeat (6) step();
        chk("stall_valid", 128'(pkt_valid), 128'(1));
        ready_pct = 100;
        step();
        n = win_log.size();
        step();
        chk("resume_xfer", 128'(win_log.size()), 128'(n + 1));
        auto_done = 1'b1;
        run_phase(200);

        // Done asserted everywhere while requester 4 still holds its last record.
        rq[4].push_back(rand_rec());
        rq[4].push_back(rand_rec());
        rq[7].push_back(rand_rec());
        ready_pct = 60;
        start_phase();
        run_phase(200);

        // Randomized phases.
        for (int p = 0; p < 3; p++) begin
            auto_done = 1'b0;
            gap_pct = 30;
            ready_pct = 70;
            for (int i = 0; i < NR; i++) begin
                n = $urandom_range(5);
                repeat (n) rq[i].push_back(rand_rec());
            end
            start_phase();
            repeat (20) step();
            auto_done = 1'b1;
            run_phase(600);
        end
        gap_pct = 0;

        // Reset during RUN with a stalled packet.
        auto_done = 1'b0;
        ready_pct = 0;
        for (int i = 1; i < 4; i++) repeat (3) rq[i].push_back(rand_rec());
        start_phase();
        repeat (3) step();
        chk("pre_rst_valid", 128'(pkt_valid), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pkt_valid", 128'(pkt_valid), 128'(0));
        chk("mid_rst_pkt_data", 128'(pkt_data), 128'(0));
        chk("mid_rst_req_ready", 128'(req_ready), 128'(0));
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_pkt_count", 128'(pkt_count), 128'(0));
        for (int i = 0; i < NR; i++) rq[i].delete();
        exp_q.delete();
        req_valid = '0;
        req_done = '0;
        rr_next = 0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_pct = 100;
        pkt_ready = 1'b1;
        rq[0].push_back(rand_rec());
        auto_done = 1'b1;
        start_phase();
        run_phase(50);

`ifdef WB_ARB_CELL_CHECK_EN
        // Illegal cell {1,1,1} is consumed without a packet.
        rq[0].push_back(mk_rec({3'd1, 3'd1, 3'd1}));
        rq[1].push_back(rand_rec());
        start_phase();
        run_phase(50);
        chk("err_phase_pkts", 128'(phase_exp), 128'(1));
        rq[2].push_back(rand_rec());
        start_phase();
        run_phase(50);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual expired required finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wb_pkt_arbiter.md
# wb_pkt_arbiter

Per-cell force writeback scheduler: shares one `cell_to_dest_id_map` instance and one network injection port among the NUM_REQ half-shell neighbor writeback sources of a home cell. It also sequences the writeback phase from start to done. Writeback records are granted round-robin, mapped to destination node IDs, and presented as registered packets under a valid/ready handshake. Completion is signalled only after every source has finished and the output register has drained.

## Interface
- NUM_REQ, 13, number of writeback requesters (one per half-shell neighbor cell)
- DATA_WIDTH, 32, force component width
- CELL_ID_WIDTH, 3, per-axis cell ID width
- PARTICLE_ID_WIDTH, 7, particle ID width
- ID_WIDTH, 3*CELL_ID_WIDTH+PARTICLE_ID_WIDTH, full particle ID width
- WB_WIDTH, ID_WIDTH+3*DATA_WIDTH, writeback record width, laid out as {cellz, celly, cellx, pid, force}
- NODE_ID_WIDTH, 6, destination node ID width
- PACKET_WIDTH, 3*DATA_WIDTH+PARTICLE_ID_WIDTH+NODE_ID_WIDTH, output packet width
- NUM_CELLS / HOME_CELL_ID / HOME_X / HOME_Y / HOME_Z / NX / NY / NZ, 64 / 0 / 1 / 1 / 1 / 4 / 4 / 4, passed unchanged to the mapper
- CNT_WIDTH, 16, packet counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- phase_start  in  1  one-cycle pulse that opens a writeback phase
- req_valid  in  NUM_REQ  per-requester record valid
- req_data  in  NUM_REQ*WB_WIDTH  records; requester i occupies slice [i*WB_WIDTH +: WB_WIDTH]
- req_done  in  NUM_REQ  requester i has no further records; level, captured sticky
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] && req_ready[i]
- pkt_valid  out  1  output packet valid
- pkt_data  out  PACKET_WIDTH  {dest_id, pid, force}
- pkt_ready  in  1  network accepts the packet
- busy  out  1  high in every state except IDLE
- phase_done  out  1  one-cycle pulse at end of phase
- pkt_count  out  CNT_WIDTH  packets sent in the current or last phase

## Operation
FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - req_ready = 0.
  - Goes to RUN on phase_start.
  - On that transition, the done mask, pkt_count and the round-robin pointer are cleared to 0.
- RUN:
  - Round-robin arbitration among asserted req_valid, starting the search at the pointer.
  - The output stage can accept when !pkt_valid || pkt_ready. When it can, the winner gets req_ready.
  - On each transfer: the pointer becomes winner+1, wrapping from NUM_REQ-1 to 0.
  - done_mask |= req_done every cycle.
  - Goes to DRAIN when done_mask is all ones and req_valid is all zeros in the same cycle.
  - A requester may assert req_done together with its final req_valid; that record is still arbitrated.
- DRAIN:
  - req_ready = 0.
  - Goes to DONE once the output register is empty, or when a transfer (pkt_valid && pkt_ready) occurs in that cycle.
- DONE: phase_done = 1 for one cycle, then IDLE.
- phase_start outside IDLE is ignored.
- The granted record passes combinationally through the `cell_to_dest_id_map` instance and is registered into pkt_data / pkt_valid.
- pkt_count increments on each output transfer and saturates at all ones. It holds its value in IDLE until the next phase_start.
- Requester data not in a half-shell cell is a protocol error; see Configuration.

## Timing
- Reset: state IDLE, pkt_valid 0, pkt_data 0, req_ready 0, phase_done 0, busy 0, pkt_count 0, pointer 0, done mask 0.
- Reset asserted mid-phase aborts immediately. An in-flight packet is discarded and not counted.
- Latency is 1 cycle from the accepted request to pkt_valid. Throughput is 1 packet/cycle while pkt_ready = 1.
- While pkt_valid && !pkt_ready: pkt_data is held stable and req_ready is all 0.
- req_ready is combinational from req_valid, the pointer, state, pkt_valid and pkt_ready. Requesters must not make req_valid depend on req_ready.
- phase_done is asserted no earlier than 2 cycles after the last output transfer: DRAIN then DONE.

## Configuration
- WB_ARB_CELL_CHECK_EN defined:
  - A granted record whose {cellz, celly, cellx} is not one of the 13 half-shell codes is consumed (req_ready asserted) but not loaded into the output register.
  - A sticky output err_cell (1 bit, reset 0, cleared on phase_start) is set.
  - The mapper is fed a fixed legal code for that cycle, so it never sees the illegal ID.
- Undefined: the err_cell port is absent, there is no check, and illegal IDs reach the mapper.

## Structure
- Shared package wb_pkg:
  - state enum wb_arb_state_t (IDLE, RUN, DRAIN, DONE)
  - cell code localparams CELL_1=3'b001, CELL_2=3'b010, CELL_3=3'b011
  - half-shell code list used by the check
- Natural sub-module: rr_arbiter.
  - Parameterized by NUM_REQ.
  - Inputs: request vector, enable, pointer.
  - Outputs: one-hot grant and binary winner index.
- The block instantiates rr_arbiter and `cell_to_dest_id_map`.

## Test plan
- Single requester, HOME_CELL_ID=0 at (1,1,1) in a 4x4x4 grid. phase_start, then requester 0 sends cell {2,2,3} and req_done → one packet with dest_id=1, pkt_count=1, phase_done 2 cycles later.
- All 13 requesters valid every cycle, pkt_ready=1 → grants rotate 0,1,…,12,0; one packet per cycle; no requester granted twice within 13 cycles.
- pkt_ready held low 5 cycles with pkt_valid=1 → pkt_data unchanged, req_ready all 0; transfers resume the cycle after pkt_ready rises.
- req_done asserted on all requesters while requester 4 still holds its last valid → that record is sent, then DRAIN, then phase_done; pkt_count matches the records sent.
- rst_n pulsed low mid-RUN with pkt_valid=1 → all outputs zero immediately, state IDLE, later phase_start starts cleanly with pkt_count=0.
- With WB_ARB_CELL_CHECK_EN, a record with cell {1,1,1} is consumed, err_cell=1, and no pkt_valid is produced for it.
